// File: rtl/uart_pkg.sv
// Shared constants and helpers for the oversampling UART receive path.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Clock cycles per 16x tick minus one; indices above 115200 fall back to 115200.
    function automatic int div_for(input int clk_freq, input logic [2:0] baud_idx);
        int baud;
        case (baud_idx)
            BAUD_9600:  baud = 32'd9600;
            BAUD_19200: baud = 32'd19200;
            BAUD_38400: baud = 32'd38400;
            BAUD_57600: baud = 32'd57600;
            default:    baud = 32'd115200;
        endcase
        return clk_freq / (baud * 32'd16) - 32'd1;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_sync_fifo.sv
// First-word-fall-through receive FIFO with occupancy count; wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             valid_r;
    logic             full_s;
    logic             empty_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign pop_ok_s  = pop & ~empty_s;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + (AW+1)'(1);
            2'b01:   count_s = count_r - (AW+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Pointer, count and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            count_r <= count_s;
            valid_r <= (count_s != '0);
        end
    end

    assign pop_data = mem_r[rd_ptr_r[AW-1:0]];
    assign full     = full_s;
    assign valid    = valid_r;
    assign count    = count_r;

endmodule

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver with majority voting, optional parity and a FWFT FIFO.
// Define UART_RX_FRAME_TIMEOUT_EN to add the Rx_idle_timeout packet-end pulse.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int PARITY_MODE = 0
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Uart_rx,
    input  logic [2:0]                    Baud_sel,
    output logic [DATA_BITS-1:0]          Rx_data,
    output logic                          Rx_valid,
    input  logic                          Rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   Rx_count,
    output logic                          Frame_err,
    output logic                          Parity_err,
    output logic                          Overrun_err,
`ifdef UART_RX_FRAME_TIMEOUT_EN
    output logic                          Rx_idle_timeout,
`endif
    output logic                          Busy
);

    localparam int DIV_9600   = div_for(CLK_FREQ, BAUD_9600);
    localparam int DIV_19200  = div_for(CLK_FREQ, BAUD_19200);
    localparam int DIV_38400  = div_for(CLK_FREQ, BAUD_38400);
    localparam int DIV_57600  = div_for(CLK_FREQ, BAUD_57600);
    localparam int DIV_115200 = div_for(CLK_FREQ, BAUD_115200);
    localparam int DIV_W      = (DIV_9600 > 0) ? $clog2(DIV_9600 + 1) : 1;

    function automatic logic [DIV_W-1:0] div_lookup(input logic [2:0] sel);
        case (sel)
            BAUD_9600:  return DIV_W'(DIV_9600);
            BAUD_19200: return DIV_W'(DIV_19200);
            BAUD_38400: return DIV_W'(DIV_38400);
            BAUD_57600: return DIV_W'(DIV_57600);
            default:    return DIV_W'(DIV_115200);
        endcase
    endfunction

    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    logic                 sync1_r, sync2_r, prev_r;
    logic                 fall_s;
    rx_state_e            state_r, state_s;
    logic [DIV_W-1:0]     div_r;
    logic [DIV_W-1:0]     tick_cnt_r;
    logic                 tick_s;
    logic [3:0]           sub_r;
    logic [3:0]           bit_cnt_r;
    logic [1:0]           samp_r;
    logic                 vote_s;
    logic [DATA_BITS-1:0] shift_r;
    logic                 par_r;
    logic                 decide_s;
    logic                 par_mis_s;
    logic                 frame_bad_s, par_bad_s, good_s;
    logic                 pop_s, push_s, overrun_s;
    logic                 fifo_full_s;
    logic                 frame_err_r, parity_err_r, overrun_err_r, busy_r;

    assign fall_s    = prev_r & ~sync2_r;
    assign tick_s    = (state_r != ST_IDLE) && (tick_cnt_r == div_r);
    assign vote_s    = maj3(samp_r[0], samp_r[1], sync2_r);
    assign par_mis_s = (PARITY_MODE != PAR_NONE) && (par_r != expected_parity(shift_r));

    // Two-flop synchroniser plus edge-detect stage, idle-high after reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= Uart_rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state logic; decisions happen on the tick at subsample 9 or 15.
    always_comb begin
        state_s  = state_r;
        decide_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) state_s = ST_START;
                else        state_s = ST_IDLE;
            end
            ST_START: begin
                if (tick_s && sub_r == 4'd9 && vote_s) state_s = ST_IDLE;
                else if (tick_s && sub_r == 4'd15)    state_s = ST_DATA;
                else                                   state_s = ST_START;
            end
            ST_DATA: begin
                if (tick_s && sub_r == 4'd15 && bit_cnt_r == 4'(DATA_BITS - 1))
                    state_s = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                else
                    state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (tick_s && sub_r == 4'd15) state_s = ST_STOP;
                else                          state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (tick_s && sub_r == 4'd9) begin
                    state_s  = ST_IDLE;
                    decide_s = 1'b1;
                end else begin
                    state_s  = ST_STOP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    assign frame_bad_s = decide_s & ~vote_s;
    assign par_bad_s   = decide_s & vote_s & par_mis_s;
    assign good_s      = decide_s & vote_s & ~par_mis_s;
    assign pop_s       = Rx_valid & Rx_ready;
    assign push_s      = good_s & (~fifo_full_s | pop_s);
    assign overrun_s   = good_s & fifo_full_s & ~pop_s;

    // State register and registered status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            busy_r        <= (state_s != ST_IDLE);
            frame_err_r   <= frame_bad_s;
            parity_err_r  <= par_bad_s;
            overrun_err_r <= overrun_s;
        end
    end

    // Tick divider, subsample counter and bit capture; all held clear while idle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_r      <= '0;
            tick_cnt_r <= '0;
            sub_r      <= 4'd0;
            bit_cnt_r  <= 4'd0;
            samp_r     <= 2'b11;
            shift_r    <= '0;
            par_r      <= 1'b0;
        end else if (state_r == ST_IDLE) begin
            tick_cnt_r <= '0;
            sub_r      <= 4'd0;
            bit_cnt_r  <= 4'd0;
            if (fall_s) div_r <= div_lookup(Baud_sel);
        end else if (tick_s) begin
            tick_cnt_r <= '0;
            sub_r      <= sub_r + 4'd1;
            if (sub_r == 4'd7) samp_r[0] <= sync2_r;
            if (sub_r == 4'd8) samp_r[1] <= sync2_r;
            if (sub_r == 4'd9 && state_r == ST_DATA)   shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
            if (sub_r == 4'd9 && state_r == ST_PARITY) par_r   <= vote_s;
            if (sub_r == 4'd15 && state_r == ST_DATA)  bit_cnt_r <= bit_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (pop_s),
        .pop_data  (Rx_data),
        .full      (fifo_full_s),
        .valid     (Rx_valid),
        .count     (Rx_count)
    );

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam logic [9:0] TO_LAST = 10'd639;

    logic             to_armed_r;
    logic             to_pulse_r;
    logic [DIV_W-1:0] to_div_r;
    logic [9:0]       to_cnt_r;

    // Counts 40 bit periods of high idle line at the latched baud after a good frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            to_armed_r <= 1'b0;
            to_pulse_r <= 1'b0;
            to_div_r   <= '0;
            to_cnt_r   <= 10'd0;
        end else begin
            to_pulse_r <= 1'b0;
            if (good_s) begin
                to_armed_r <= 1'b1;
                to_div_r   <= '0;
                to_cnt_r   <= 10'd0;
            end else if (state_r != ST_IDLE || !sync2_r || !to_armed_r) begin
                to_div_r   <= '0;
                to_cnt_r   <= 10'd0;
            end else if (to_div_r == div_r) begin
                to_div_r <= '0;
                if (to_cnt_r == TO_LAST) begin
                    to_pulse_r <= 1'b1;
                    to_armed_r <= 1'b0;
                    to_cnt_r   <= 10'd0;
                end else begin
                    to_cnt_r <= to_cnt_r + 10'd1;
                end
            end else begin
                to_div_r <= to_div_r + DIV_W'(1);
            end
        end
    end

    assign Rx_idle_timeout = to_pulse_r;
`endif

    assign Frame_err   = frame_err_r;
    assign Parity_err  = parity_err_r;
    assign Overrun_err = overrun_err_r;
    assign Busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: instance A is 8N1 depth 16, instance B is 8E1 depth 4, both at 115200.
module tb_uart_rx_frame;

    localparam int CLK_FREQ = 7_372_800;   // 4 clocks per 16x tick at 115200
    localparam int BIT      = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_a = 1'b1, line_b = 1'b1;
    logic ready_a = 1'b0, ready_b = 1'b0;
    logic [2:0] baud_sel = 3'd4;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic [4:0] count_a;
    logic [2:0] count_b;
    logic       ferr_a, perr_a, oerr_a, busy_a;
    logic       ferr_b, perr_b, oerr_b, busy_b;
`ifdef UART_RX_FRAME_TIMEOUT_EN
    logic       to_a, to_b;
`endif

    int checks = 0;
    int errors = 0;
    int ferr_cnt_a = 0;

    logic [7:0] exp_word_a[$];
    logic [7:0] exp_word_b[$];
    int         exp_err_a[$];
    int         exp_err_b[$];

    always #5 clk = ~clk;

    uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .FIFO_DEPTH(16), .PARITY_MODE(0)) u_a (
        .Clk(clk), .Rst_n(rst_n), .Uart_rx(line_a), .Baud_sel(baud_sel),
        .Rx_data(data_a), .Rx_valid(valid_a), .Rx_ready(ready_a), .Rx_count(count_a),
        .Frame_err(ferr_a), .Parity_err(perr_a), .Overrun_err(oerr_a),
`ifdef UART_RX_FRAME_TIMEOUT_EN
        .Rx_idle_timeout(to_a),
`endif
        .Busy(busy_a));

    uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_MODE(1)) u_b (
        .Clk(clk), .Rst_n(rst_n), .Uart_rx(line_b), .Baud_sel(baud_sel),
        .Rx_data(data_b), .Rx_valid(valid_b), .Rx_ready(ready_b), .Rx_count(count_b),
        .Frame_err(ferr_b), .Parity_err(perr_b), .Overrun_err(oerr_b),
`ifdef UART_RX_FRAME_TIMEOUT_EN
        .Rx_idle_timeout(to_b),
`endif
        .Busy(busy_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic sb_word(input int idx, input logic [7:0] got);
        logic [7:0] exp;
        checks++;
        if ((idx == 0 && exp_word_a.size() == 0) || (idx == 1 && exp_word_b.size() == 0)) begin
            errors++;
            $display("FAIL word%0d unexpected read got=%0h", idx, got);
        end else begin
            exp = (idx == 0) ? exp_word_a.pop_front() : exp_word_b.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL word%0d got=%0h exp=%0h", idx, got, exp);
            end
        end
    endtask

    // kind: 1 = frame, 2 = parity, 3 = overrun
    task automatic sb_err(input int idx, input int kind);
        int exp;
        checks++;
        if ((idx == 0 && exp_err_a.size() == 0) || (idx == 1 && exp_err_b.size() == 0)) begin
            errors++;
            $display("FAIL err%0d unexpected pulse got=%0d exp=none", idx, kind);
        end else begin
            exp = (idx == 0) ? exp_err_a.pop_front() : exp_err_b.pop_front();
            if (kind != exp) begin
                errors++;
                $display("FAIL err%0d kind got=%0d exp=%0d", idx, kind, exp);
            end
        end
    endtask

    // Monitor: compares every handshake and every error pulse against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_a && ready_a) sb_word(0, data_a);
            if (valid_b && ready_b) sb_word(1, data_b);
            if (ferr_a) begin sb_err(0, 1); ferr_cnt_a++; end
            if (perr_a) sb_err(0, 2);
            if (oerr_a) sb_err(0, 3);
            if (ferr_b) sb_err(1, 1);
            if (perr_b) sb_err(1, 2);
            if (oerr_b) sb_err(1, 3);
        end
    end

    task automatic set_line(input int idx, input logic v);
        if (idx == 0) line_a = v;
        else          line_b = v;
    endtask

    task automatic hold(input int idx, input logic v, input int cycles);
        set_line(idx, v);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // par: 0 = no parity bit, 1 = correct even parity, 2 = flipped parity
    task automatic send_frame(input int idx, input logic [7:0] d, input int par, input logic stop);
        hold(idx, 1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(idx, d[i], BIT);
        if (par != 0) hold(idx, (^d) ^ (par == 2), BIT);
        hold(idx, stop, BIT);
        hold(idx, 1'b1, BIT);
    endtask

    task automatic pop_n(input int idx, input int n);
        if (idx == 0) ready_a = 1'b1;
        else          ready_b = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  fe0;
        int  busy_cycles;
        bit  seen;
        logic prev_busy;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_a", {14'd0, data_a, valid_a, count_a, ferr_a, perr_a, oerr_a, busy_a}, 32'd0);
        check("reset_b", {16'd0, data_b, valid_b, count_b, ferr_b, perr_b, oerr_b, busy_b}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(0, 1'b1, BIT);

        // 0x55 8N1: valid must appear the cycle after the last busy (decision) cycle
        exp_word_a.push_back(8'h55);
        fork
            send_frame(0, 8'h55, 0, 1'b1);
            begin
                seen = 1'b0;
                prev_busy = 1'b0;
                for (int i = 0; i < 15 * BIT && !seen; i++) begin
                    @(negedge clk);
                    if (valid_a) begin
                        seen = 1'b1;
                        check("valid_after_decision", {prev_busy, busy_a}, 2'b10);
                        check("count_after_55", 32'(count_a), 32'd1);
                    end
                    prev_busy = busy_a;
                end
                if (!seen) check("valid_timeout_55", 32'd0, 32'd1);
            end
        join
        pop_n(0, 1);
        @(negedge clk);
        check("count_after_pop_55", 32'(count_a), 32'd0);
        @(posedge clk); #1;

        // 3-cycle glitch: brief Busy, nothing stored
        hold(0, 1'b0, 3);
        set_line(0, 1'b1);
        busy_cycles = 0;
        for (int i = 0; i < 2 * BIT; i++) begin
            @(negedge clk);
            if (busy_a) busy_cycles++;
        end
        check("glitch_busy_seen", 32'(busy_cycles > 0), 32'd1);
        check("glitch_busy_short", 32'(busy_cycles < BIT), 32'd1);
        check("glitch_busy_end", 32'(busy_a), 32'd0);
        check("glitch_count", 32'(count_a), 32'd0);
        @(posedge clk); #1;

        // 0x3C with stop low, then a 3-frame break
        exp_err_a.push_back(1);
        send_frame(0, 8'h3C, 0, 1'b0);
        @(negedge clk);
        check("count_after_ferr", 32'(count_a), 32'd0);
        @(posedge clk); #1;
        fe0 = ferr_cnt_a;
        exp_err_a.push_back(1);
        hold(0, 1'b0, 30 * BIT);
        hold(0, 1'b1, 2 * BIT);
        check("break_single_ferr", 32'(ferr_cnt_a - fe0), 32'd1);
        check("break_count", 32'(count_a), 32'd0);

        // Baud_sel 7 acts as 115200; a change mid-frame must not disturb reception
        baud_sel = 3'd7;
        exp_word_a.push_back(8'hC3);
        fork
            send_frame(0, 8'hC3, 0, 1'b1);
            begin
                repeat (BIT / 2 + 10) @(posedge clk);
                #1 baud_sel = 3'd0;
            end
        join
        baud_sel = 3'd4;
        @(negedge clk);
        check("count_c3", 32'(count_a), 32'd1);
        @(posedge clk); #1;
        pop_n(0, 1);

        // Even parity on B: flipped parity rejected, correct parity stored
        hold(1, 1'b1, BIT);
        exp_err_b.push_back(2);
        send_frame(1, 8'hA5, 2, 1'b1);
        @(negedge clk);
        check("count_after_perr", 32'(count_b), 32'd0);
        @(posedge clk); #1;
        exp_word_b.push_back(8'hA5);
        send_frame(1, 8'hA5, 1, 1'b1);
        @(negedge clk);
        check("count_a5", 32'(count_b), 32'd1);
        @(posedge clk); #1;
        pop_n(1, 1);

        // Overfill depth-4 FIFO: fifth word is dropped with an overrun
        for (int k = 1; k <= 4; k++) exp_word_b.push_back(8'(k));
        exp_err_b.push_back(3);
        for (int k = 1; k <= 5; k++) send_frame(1, 8'(k), 1, 1'b1);
        @(negedge clk);
        check("count_full", 32'(count_b), 32'd4);
        check("valid_full", 32'(valid_b), 32'd1);
        @(posedge clk); #1;
        pop_n(1, 4);
        @(negedge clk);
        check("count_drained", 32'(count_b), 32'd0);
        check("valid_drained", 32'(valid_b), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of 0xF0's data bits, then receive 0x0F
        hold(0, 1'b0, BIT);
        hold(0, 1'b0, 3 * BIT);
        hold(0, 1'b0, BIT / 2);
        check("busy_before_reset", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        line_a = 1'b1;
        @(negedge clk);
        check("mid_reset_a", {14'd0, data_a, valid_a, count_a, ferr_a, perr_a, oerr_a, busy_a}, 32'd0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(0, 1'b1, 2 * BIT);
        check("after_reset_idle", {30'd0, busy_a, valid_a}, 32'd0);
        exp_word_a.push_back(8'h0F);
        send_frame(0, 8'h0F, 0, 1'b1);
        @(negedge clk);
        check("count_0f", 32'(count_a), 32'd1);
        @(posedge clk); #1;
        pop_n(0, 1);
        repeat (4) @(posedge clk);

        check("left_words_a", 32'(exp_word_a.size()), 32'd0);
        check("left_words_b", 32'(exp_word_b.size()), 32'd0);
        check("left_errs_a", 32'(exp_err_a.size()), 32'd0);
        check("left_errs_b", 32'(exp_err_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised successor to the single-byte UART receive path.
- Oversamples the serial line 16x with majority voting; supports configurable data width, optional parity and selectable baud.
- Pushes received words into an internal FIFO with a valid/ready read interface and reports framing, parity and overrun errors.
- Sits between the board-level Uart_rx pin and downstream command/probe logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 16, receive FIFO entries; must be a power of 2, minimum 2.
- PARITY_MODE, 0, parity check: 0 = none, 1 = even, 2 = odd.

Ports:
- Clk  input  1  system clock.
- Rst_n  input  1  asynchronous active-low reset.
- Uart_rx  input  1  serial line, asynchronous to Clk, idle high.
- Baud_sel  input  3  baud select: 0 = 9600, 1 = 19200, 2 = 38400, 3 = 57600, 4 = 115200; 5..7 map to 115200. Sampled only in IDLE.
- Rx_data  output  DATA_BITS  FIFO head word.
- Rx_valid  output  1  FIFO not empty.
- Rx_ready  input  1  consumer pops the head when Rx_valid && Rx_ready.
- Rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- Frame_err  output  1  one-cycle pulse when the stop bit samples low.
- Parity_err  output  1  one-cycle pulse when parity mismatches.
- Overrun_err  output  1  one-cycle pulse when a good frame completes while the FIFO is full.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs are 0; the FIFO is emptied; the FSM goes to IDLE.
- Input sync: Uart_rx passes through a 2-flop synchroniser reset to 1, plus one more register for falling-edge detection.
- Tick generator: divider = CLK_FREQ/(baud*16) - 1, computed from localparams selected by the latched Baud_sel. The counter is cleared while in IDLE and produces a 1-cycle tick at 16x baud.
- Per-bit sampling: a 4-bit subsample counter runs per bit. Samples are taken at subsamples 7, 8 and 9, and the bit value is the 2-of-3 majority vote.
- FSM states and transitions:
  - IDLE: on a synchronised falling edge, latch Baud_sel and go to START.
  - START: at subsample 9, if the voted value is 1 (glitch), go back to IDLE with no error. Otherwise go to DATA at subsample 15.
  - DATA: shift in LSB first over DATA_BITS bits. Then go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: sample the parity bit and compare it with the reduction XOR of the data (XNOR for odd parity). Go to STOP.
  - STOP: at subsample 9, decide the frame and go to IDLE. The FSM does not wait out the rest of the stop bit.
- Frame decision at STOP subsample 9:
  - Stop bit = 0: pulse Frame_err and discard the word.
  - Parity bad (stop good): pulse Parity_err and discard the word.
  - Good frame: write to the FIFO if there is space. If the FIFO is full, drop the new word, keep the FIFO contents and pulse Overrun_err.
- Write latency: a FIFO write lands 1 cycle after the decision cycle. Rx_valid rises in that same cycle.
- FIFO: first-word-fall-through. Rx_data is valid whenever Rx_valid is high.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - Full when the MSBs differ and the remaining bits are equal.
- Simultaneous push and pop:
  - Both are accepted and Rx_count is unchanged.
  - When the FIFO is full, a simultaneous pop frees a slot, so the push succeeds with no overrun.
- Popping while empty is ignored.
- Reset mid-frame: the FSM aborts immediately and the FIFO is cleared. After reset, the first falling edge starts a new frame.
- A break condition (line held low) gives a Frame_err for that frame. The FSM then waits in IDLE for the line to return high before arming, so the break produces no repeated errors.

Optional Feature:
- Macro: UART_RX_FRAME_TIMEOUT_EN.
- When defined:
  - An extra output Rx_idle_timeout (1 bit) is added.
  - It pulses for 1 cycle after the line has been idle for 4 character times (40 bit periods at the latched baud) following at least one received frame.
  - It re-arms after the next received frame.
  - This provides packet-end detection.
- When undefined, the port and its counter do not exist.

Decomposition:
- Package uart_pkg holds:
  - Baud-index constants (BAUD_9600..BAUD_115200).
  - Parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
  - A divider function div_for(clk_freq, baud_idx).
- One natural sub-module: sync_fifo (parametrised WIDTH and DEPTH, FWFT, with a count output), instantiated once.
- The FSM, tick generator and synchroniser stay in the top level.

Test Plan:
- Reset, then send 0x55, 8N1, Baud_sel=4 -> Rx_valid rises 1 cycle after the stop decision, Rx_data=0x55, Rx_count=1. Popping with Rx_ready=1 gives Rx_count=0 and no error pulses.
- 3-sample-wide low glitch on an idle line -> no Busy beyond START, no FIFO write, no errors.
- PARITY_MODE=1, send 0xA5 with the parity bit flipped -> Parity_err pulses once and Rx_count stays 0. With correct parity, 0xA5 is stored.
- Stop bit forced low on 0x3C -> Frame_err pulses and the word is discarded. Holding the line low for 3 frame times afterwards gives exactly one Frame_err.
- FIFO_DEPTH=4, Rx_ready=0, send 0x01..0x05 -> Rx_count=4 and Overrun_err pulses on 0x05. Popping then returns 0x01,0x02,0x03,0x04.
- Assert Rst_n low mid-way through the DATA bits of 0xF0 -> outputs are 0 and no word is stored. The next frame 0x0F is received correctly.
